// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing one cache controller command port
// among NUM_REQ requesters, one whole transaction per grant.
module cache_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int OP_WIDTH       = 2,
  parameter int KEY_WIDTH      = 16,
  parameter int VAL_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*OP_WIDTH-1:0]    req_op_i,
  input  logic [NUM_REQ*KEY_WIDTH-1:0]   req_key_i,
  input  logic [NUM_REQ*VAL_WIDTH-1:0]   req_val_i,
  output logic [NUM_REQ-1:0]             resp_valid_o,
  output logic [VAL_WIDTH-1:0]           resp_data_o,
  output logic                           resp_err_o,
  output logic                           resp_timeout_o,
  output logic                           ctrl_valid_o,
  input  logic                           ctrl_ready_i,
  output logic [OP_WIDTH-1:0]            ctrl_op_o,
  output logic [KEY_WIDTH-1:0]           ctrl_key_o,
  output logic [VAL_WIDTH-1:0]           ctrl_val_o,
  input  logic                           ctrl_done_i,
  input  logic                           ctrl_error_i,
  input  logic [VAL_WIDTH-1:0]           ctrl_data_i,
  output logic [NUM_REQ-1:0]             grant_o,
  output logic                           busy_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        last_q, last_d;
  logic [IW-1:0]        gidx_q, gidx_d;
  logic [OP_WIDTH-1:0]  op_q, op_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [VAL_WIDTH-1:0] val_q, val_d;
  logic [VAL_WIDTH-1:0] data_q, data_d;
  logic                 err_q, err_d;
  logic                 tmo_q, tmo_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic [OP_WIDTH-1:0]  op_arr  [NUM_REQ];
  logic [KEY_WIDTH-1:0] key_arr [NUM_REQ];
  logic [VAL_WIDTH-1:0] val_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign op_arr[i]  = req_op_i[i*OP_WIDTH +: OP_WIDTH];
    assign key_arr[i] = req_key_i[i*KEY_WIDTH +: KEY_WIDTH];
    assign val_arr[i] = req_val_i[i*VAL_WIDTH +: VAL_WIDTH];
  end

  // Scan starts one past the last served requester.
  logic               pick_vld;
  logic [IW-1:0]      pick_idx;
  logic [NUM_REQ-1:0] pick_oh;
  int                 cand;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!pick_vld && req_valid_i[cand[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    pick_oh = '0;
    if (pick_vld) pick_oh[pick_idx] = 1'b1;
  end

  logic [NUM_REQ-1:0] gnt_oh;

  always_comb begin
    gnt_oh = '0;
    gnt_oh[gidx_q] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gidx_d      = gidx_q;
    op_d        = op_q;
    key_d       = key_q;
    val_d       = val_q;
    data_d      = data_q;
    err_d       = err_q;
    tmo_d       = tmo_q;
    cnt_d       = cnt_q;
    req_ready_o = '0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          req_ready_o = pick_oh;
          gidx_d      = pick_idx;
          op_d        = op_arr[pick_idx];
          key_d       = key_arr[pick_idx];
          val_d       = val_arr[pick_idx];
          data_d      = '0;
          err_d       = 1'b0;
          tmo_d       = 1'b0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ctrl_ready_i) begin
          if (ctrl_done_i) begin
            data_d  = ctrl_data_i;
            err_d   = ctrl_error_i;
            tmo_d   = 1'b0;
            state_d = S_RESP;
          end else begin
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // A completion in the final cycle beats the timeout.
        if (ctrl_done_i) begin
          data_d  = ctrl_data_i;
          err_d   = ctrl_error_i;
          tmo_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_MAX) begin
          data_d  = '0;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        last_d  = gidx_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= LAST_RST;
      gidx_q  <= '0;
      op_q    <= '0;
      key_q   <= '0;
      val_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gidx_q  <= gidx_d;
      op_q    <= op_d;
      key_q   <= key_d;
      val_q   <= val_d;
      data_q  <= data_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  logic in_resp;

  assign in_resp        = (state_q == S_RESP);
  assign busy_o         = (state_q != S_IDLE);
  assign grant_o        = busy_o ? gnt_oh : '0;
  assign resp_valid_o   = in_resp ? gnt_oh : '0;
  assign resp_data_o    = in_resp ? data_q : '0;
  assign resp_err_o     = in_resp & err_q;
  assign resp_timeout_o = in_resp & tmo_q;
  assign ctrl_valid_o   = (state_q == S_ISSUE);
  assign ctrl_op_o      = op_q;
  assign ctrl_key_o     = key_q;
  assign ctrl_val_o     = val_q;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Bench for cache_req_arbiter: vector table, directed corner
// sequences and a randomized run against a transaction-level model.
module tb_cache_req_arbiter;

  localparam int TO = 64;

  logic        clk;
  logic        rst_n;
  logic [3:0]  vld;
  logic [1:0]  pop  [4];
  logic [15:0] pkey [4];
  logic [31:0] pval [4];
  logic        crdy, cdone, cerr;
  logic [31:0] cdata;

  logic [3:0]  req_ready_o, resp_valid_o, grant_o;
  logic [7:0]  req_op_i;
  logic [63:0] req_key_i;
  logic [127:0] req_val_i;
  logic [31:0] resp_data_o, ctrl_val_o;
  logic        resp_err_o, resp_timeout_o, ctrl_valid_o, busy_o;
  logic [1:0]  ctrl_op_o;
  logic [15:0] ctrl_key_o;

  assign req_op_i  = {pop[3], pop[2], pop[1], pop[0]};
  assign req_key_i = {pkey[3], pkey[2], pkey[1], pkey[0]};
  assign req_val_i = {pval[3], pval[2], pval[1], pval[0]};

  cache_req_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(vld), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_key_i(req_key_i),
    .req_val_i(req_val_i),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o),
    .resp_err_o(resp_err_o), .resp_timeout_o(resp_timeout_o),
    .ctrl_valid_o(ctrl_valid_o), .ctrl_ready_i(crdy),
    .ctrl_op_o(ctrl_op_o), .ctrl_key_o(ctrl_key_o),
    .ctrl_val_o(ctrl_val_o), .ctrl_done_i(cdone),
    .ctrl_error_i(cerr), .ctrl_data_i(cdata),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int i);
    logic [3:0] r;
    r = '0;
    if (i >= 0) r[i[1:0]] = 1'b1;
    return r;
  endfunction

  function automatic int rr_pick(input int lst, input logic [3:0] v);
    int c;
    for (int o = 1; o <= 4; o++) begin
      c = (lst + o) % 4;
      if (v[c[1:0]]) return c;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    vld = '0; crdy = 0; cdone = 0; cerr = 0; cdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  vld;
    logic        rdy, dn, er;
    logic [31:0] cd;
    logic [3:0]  e_rdy;
    logic        e_cv;
    int          e_g;
    logic [3:0]  e_rsp;
    logic [31:0] e_dat;
    logic        e_err, e_tmo;
  } vec_t;

  vec_t tbl [21];

  int acc_c[$], acc_i[$], rsp_c[$];
  int n;

  // Random-run model state
  int last, macc, midx, mresp, mdone_at, pick, r;
  bit mb, mhs, hs_now, in_issue;
  logic [1:0]  mop;
  logic [15:0] mkey;
  logic [31:0] mval, mdata, ddata;
  logic        merr, mtmo, derr;
  logic [3:0]  drop, exp_rdy, exp_g;
  logic        exp_cv;

  initial begin
    rst_n = 1'b0;
    vld = '0; crdy = 0; cdone = 0; cerr = 0; cdata = '0;
    for (int i = 0; i < 4; i++) begin
      pop[i]  = 2'(i);
      pkey[i] = 16'h1000 + 16'(i);
      pval[i] = 32'hA000_0000 + 32'(i);
    end
    pop[2] = 2'd1; pkey[2] = 16'h00A5; pval[2] = 32'hDEAD_BEEF;

    tbl[0]  = '{4'b0100,1,0,0,0,         4'b0100,0,-1,4'b0,0,0,0};
    tbl[1]  = '{4'b0000,1,0,0,0,         4'b0000,1, 2,4'b0,0,0,0};
    tbl[2]  = '{4'b0000,0,1,0,32'h12345678, 4'b0,0, 2,4'b0,0,0,0};
    tbl[3]  = '{4'b0000,0,0,0,0,         4'b0,0, 2,4'b0100,32'h12345678,0,0};
    tbl[4]  = '{4'b0000,0,0,0,0,         4'b0,0,-1,4'b0,0,0,0};
    tbl[5]  = '{4'b0010,1,0,0,0,         4'b0010,0,-1,4'b0,0,0,0};
    tbl[6]  = '{4'b0000,1,1,1,32'hCAFEF00D, 4'b0,1, 1,4'b0,0,0,0};
    tbl[7]  = '{4'b0000,0,0,0,0,         4'b0,0, 1,4'b0010,32'hCAFEF00D,1,0};
    tbl[8]  = '{4'b1000,0,0,0,0,         4'b1000,0,-1,4'b0,0,0,0};
    tbl[9]  = '{4'b0001,0,0,0,0,         4'b0,1, 3,4'b0,0,0,0};
    tbl[10] = '{4'b0001,0,1,1,32'hFFFFFFFF, 4'b0,1, 3,4'b0,0,0,0};
    tbl[11] = '{4'b0001,0,0,0,0,         4'b0,1, 3,4'b0,0,0,0};
    tbl[12] = '{4'b0001,0,0,0,0,         4'b0,1, 3,4'b0,0,0,0};
    tbl[13] = '{4'b0001,0,0,0,0,         4'b0,1, 3,4'b0,0,0,0};
    tbl[14] = '{4'b0001,1,0,0,0,         4'b0,1, 3,4'b0,0,0,0};
    tbl[15] = '{4'b0001,0,1,0,32'h55,    4'b0,0, 3,4'b0,0,0,0};
    tbl[16] = '{4'b0001,0,0,0,0,         4'b0,0, 3,4'b1000,32'h55,0,0};
    tbl[17] = '{4'b0001,0,0,0,0,         4'b0001,0,-1,4'b0,0,0,0};
    tbl[18] = '{4'b0000,1,1,0,32'h77,    4'b0,1, 0,4'b0,0,0,0};
    tbl[19] = '{4'b0000,0,0,0,0,         4'b0,0, 0,4'b0001,32'h77,0,0};
    tbl[20] = '{4'b0000,0,0,0,0,         4'b0,0,-1,4'b0,0,0,0};

    #1;
    chk("rst.a", 64'({req_ready_o, resp_valid_o, grant_o, busy_o,
                      ctrl_valid_o, resp_err_o, resp_timeout_o}), 64'(0));
    chk("rst.b", 64'({resp_data_o, ctrl_op_o, ctrl_key_o}), 64'(0));
    chk("rst.c", 64'(ctrl_val_o), 64'(0));

    // Vector table: single request, error, backpressure
    do_reset();
    for (int t = 0; t < 21; t++) begin
      @(negedge clk);
      vld = tbl[t].vld; crdy = tbl[t].rdy; cdone = tbl[t].dn;
      cerr = tbl[t].er; cdata = tbl[t].cd;
      #1;
      chk($sformatf("t%0d.rdy", t), 64'(req_ready_o), 64'(tbl[t].e_rdy));
      chk($sformatf("t%0d.cv", t), 64'(ctrl_valid_o), 64'(tbl[t].e_cv));
      chk($sformatf("t%0d.gnt", t), 64'(grant_o), 64'(oh(tbl[t].e_g)));
      chk($sformatf("t%0d.busy", t), 64'(busy_o), 64'(tbl[t].e_g >= 0));
      chk($sformatf("t%0d.rsp", t),
          64'({resp_valid_o, resp_err_o, resp_timeout_o, resp_data_o}),
          64'({tbl[t].e_rsp, tbl[t].e_err, tbl[t].e_tmo, tbl[t].e_dat}));
      if (tbl[t].e_cv)
        chk($sformatf("t%0d.pay", t),
            64'({ctrl_op_o, ctrl_key_o, ctrl_val_o}),
            64'({pop[tbl[t].e_g], pkey[tbl[t].e_g], pval[tbl[t].e_g]}));
    end

    // Round-robin with single-cycle controller
    do_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      vld = 4'b1111; crdy = 1; cdone = 1; cerr = 0; cdata = 32'(c);
      #1;
      if (req_ready_o != 0) begin
        acc_c.push_back(c);
        acc_i.push_back($clog2(int'(req_ready_o)));
      end
      if (resp_valid_o != 0) rsp_c.push_back(c);
    end
    chk("rr.count", 64'(acc_c.size() >= 5 && rsp_c.size() >= 5), 64'(1));
    if (acc_c.size() >= 5 && rsp_c.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("rr.idx%0d", k), 64'(acc_i[k]), 64'(k % 4));
        chk($sformatf("rr.lat%0d", k), 64'(rsp_c[k] - acc_c[k]), 64'(2));
        if (k > 0)
          chk($sformatf("rr.gap%0d", k), 64'(acc_c[k] - acc_c[k-1]), 64'(3));
      end
    end

    // Timeout
    do_reset();
    @(negedge clk);
    vld = 4'b0011; crdy = 1; cdone = 0;
    #1;
    chk("to.acc", 64'(req_ready_o), 64'(4'b0001));
    @(negedge clk);
    vld = 4'b0010;
    #1;
    chk("to.issue", 64'({ctrl_valid_o, grant_o}), 64'({1'b1, 4'b0001}));
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      cdata = $urandom; cerr = 1'($urandom);
      #1;
      if (resp_valid_o != 0) break;
      n++;
    end
    chk("to.wait", 64'(n), 64'(TO));
    chk("to.rsp", 64'({resp_valid_o, resp_err_o, resp_timeout_o, resp_data_o}),
        64'({4'b0001, 1'b1, 1'b1, 32'h0}));
    @(negedge clk);
    #1;
    chk("to.next", 64'(req_ready_o), 64'(4'b0010));

    // Reset mid-WAIT
    do_reset();
    @(negedge clk);
    vld = 4'b1000; crdy = 1; cdone = 0;
    #1;
    chk("rw.acc", 64'(req_ready_o), 64'(4'b1000));
    @(negedge clk);
    vld = 4'b0000;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rw.a", 64'({req_ready_o, resp_valid_o, grant_o, busy_o,
                     ctrl_valid_o, resp_err_o, resp_timeout_o}), 64'(0));
    chk("rw.b", 64'({resp_data_o, ctrl_op_o, ctrl_key_o}), 64'(0));
    @(posedge clk);
    #1;
    chk("rw.norsp", 64'(resp_valid_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1; vld = 4'b1001;
    #1;
    chk("rw.prio", 64'(req_ready_o), 64'(4'b0001));

    // Randomized run against transaction-level model
    do_reset();
    last = 3; mb = 0; mhs = 0; macc = 0; midx = 0;
    mresp = -1; mdone_at = -1; drop = '0;
    mop = '0; mkey = '0; mval = '0; mdata = '0; ddata = '0;
    merr = 0; mtmo = 0; derr = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (drop[i] || (vld[i] && $urandom_range(0, 15) == 0)) begin
          vld[i]  = 1'b0;
          pop[i]  = 2'($urandom);
          pkey[i] = 16'($urandom);
          pval[i] = $urandom;
        end else if (!vld[i] && $urandom_range(0, 3) == 0) begin
          vld[i]  = 1'b1;
          pop[i]  = 2'($urandom);
          pkey[i] = 16'($urandom);
          pval[i] = $urandom;
        end
      end
      drop = '0;
      in_issue = mb && cyc > macc && !mhs;
      hs_now = 0;
      crdy  = in_issue ? ($urandom_range(0, 9) < 6) : 1'($urandom);
      cdone = 0; cerr = 1'($urandom); cdata = $urandom;
      if (in_issue && crdy) begin
        hs_now = 1;
        if ($urandom_range(0, 3) == 0) begin
          cdone = 1; mresp = cyc + 1;
          mdata = cdata; merr = cerr; mtmo = 0;
        end else begin
          r = $urandom_range(0, 9);
          if (r < 2) begin
            mdone_at = -1; mresp = cyc + TO + 1;
            mdata = '0; merr = 1; mtmo = 1;
          end else begin
            n = (r == 2) ? TO : $urandom_range(1, 8);
            mdone_at = cyc + n; mresp = cyc + n + 1;
            derr = 1'($urandom); ddata = $urandom;
            mdata = ddata; merr = derr; mtmo = 0;
          end
        end
      end else if (in_issue && $urandom_range(0, 4) == 0) begin
        cdone = 1;
      end else if (mb && mhs && cyc == mdone_at) begin
        cdone = 1; cerr = derr; cdata = ddata;
      end
      #1;
      pick = -1;
      if (!mb && vld != 0) pick = rr_pick(last, vld);
      exp_rdy = oh(pick);
      exp_cv  = in_issue;
      exp_g   = (mb && cyc > macc) ? oh(midx) : 4'b0;
      chk("rnd.rdy", 64'(req_ready_o), 64'(exp_rdy));
      chk("rnd.cv", 64'(ctrl_valid_o), 64'(exp_cv));
      chk("rnd.gnt", 64'({grant_o, busy_o}), 64'({exp_g, exp_g != 0}));
      if (exp_cv)
        chk("rnd.pay", 64'({ctrl_op_o, ctrl_key_o, ctrl_val_o}),
            64'({mop, mkey, mval}));
      if (mb && cyc == mresp)
        chk("rnd.rsp", 64'({resp_valid_o, resp_err_o, resp_timeout_o,
                            resp_data_o}),
            64'({oh(midx), merr, mtmo, mdata}));
      else
        chk("rnd.norsp", 64'({resp_valid_o, resp_err_o, resp_timeout_o,
                              resp_data_o}), 64'(0));
      if (pick >= 0) begin
        mb = 1; macc = cyc; midx = pick; mhs = 0; mresp = -1;
        mop = pop[pick]; mkey = pkey[pick]; mval = pval[pick];
        drop[pick[1:0]] = 1'b1;
      end
      if (hs_now) mhs = 1;
      if (mb && cyc == mresp) begin
        mb = 0; last = midx;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
